bram_stream_loader: RTL and testbench

- Upstream write-side feeder for the multi-bank BRAM array.
- Accepts a single AXI-Stream of WIDTH-bit words and interleaves them across BANKS banks. Word k goes to bank k mod BANKS, address k div BANKS.
- Drives the A-port bus bundle (ena/wea/addra/dina) of the bank array directly.
- Used to load kernel/weight tables before compute; start/busy/done/error give the controller a simple handshake.

---
 rtl/bram_stream_loader.sv | 131 +++++++++++++
 tb/tb_bram_stream_loader.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_loader.sv
`timescale 1ns / 1ps
// bram_stream_loader
// Feeds the A-ports of a multi-bank BRAM array from one AXI-Stream. Word k of a
// load is written to bank (k mod BANKS) at address (k div BANKS).
//
// Ports
//   clk, rstn        clock (rising edge), asynchronous active-low reset
//   start, length    one-cycle start pulse and word count, taken only in IDLE
//   busy             high while words are being accepted
//   done             one-cycle pulse when a load ends (normally or with error)
//   error            sticky: bad length or tlast mismatch; cleared on next start
//   s_axis_*         input word stream (tdata/tvalid/tready/tlast)
//   ena, wea         per-bank write strobe and byte enables (registered)
//   addra, dina      per-bank address and data, bank i in slice i
module bram_stream_loader #(
   parameter int unsigned BANKS = 4,
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 256,
   parameter int unsigned ADDR  = $clog2(DEPTH),
   parameter int unsigned WE    = WIDTH / 8,
   parameter int unsigned LEN_W = ADDR + $clog2(BANKS) + 1
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   start,
   input  logic [LEN_W-1:0]       length,
   output logic                   busy,
   output logic                   done,
   output logic                   error,
   input  logic [WIDTH-1:0]       s_axis_tdata,
   input  logic                   s_axis_tvalid,
   output logic                   s_axis_tready,
   input  logic                   s_axis_tlast,
   output logic [BANKS-1:0]       ena,
   output logic [BANKS*WE-1:0]    wea,
   output logic [BANKS*ADDR-1:0]  addra,
   output logic [BANKS*WIDTH-1:0] dina
);

   // Keep the bank selector at least one bit wide so BANKS=1 still elaborates;
   // in that case it never leaves 0.
   localparam int unsigned SELW = (BANKS > 1) ? $clog2(BANKS) : 1;
   localparam logic [LEN_W-1:0] MAXLEN = LEN_W'(BANKS * DEPTH);

   typedef enum logic [1:0] {IDLE, LOAD, FIN} state_t;

   state_t           state;
   logic [SELW-1:0]  bank_sel;
   logic [ADDR-1:0]  addr;
   logic [LEN_W-1:0] count;
   logic [LEN_W-1:0] len_q;
   logic             hs;
   logic             final_word;

   // Ready depends on state only, so the upstream never sees a tvalid->tready path.
   assign s_axis_tready = (state == LOAD);
   assign busy          = (state == LOAD);
   assign done          = (state == FIN);
   assign hs            = s_axis_tvalid & s_axis_tready;
   assign final_word    = (count == len_q - 1'b1);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         error    <= 1'b0;
         bank_sel <= '0;
         addr     <= '0;
         count    <= '0;
         len_q    <= '0;
         ena      <= '0;
         wea      <= '0;
         addra    <= '0;
         dina     <= '0;
      end else begin
         // Strobes are single-cycle; addra/dina keep their last values.
         ena <= '0;
         wea <= '0;
         case (state)
            IDLE: begin
               if (start) begin
                  bank_sel <= '0;
                  addr     <= '0;
                  count    <= '0;
                  if (length > MAXLEN) begin
                     error <= 1'b1;
                     state <= FIN;
                  end else if (length == '0) begin
                     error <= 1'b0;
                     state <= FIN;
                  end else begin
                     error <= 1'b0;
                     len_q <= length;
                     state <= LOAD;
                  end
               end
            end
            LOAD: begin
               if (hs) begin
                  for (int unsigned i = 0; i < BANKS; i++) begin
                     if (SELW'(i) == bank_sel) begin
                        ena[i]                  <= 1'b1;
                        wea[i*WE +: WE]         <= '1;
                        addra[i*ADDR +: ADDR]   <= addr;
                        dina[i*WIDTH +: WIDTH]  <= s_axis_tdata;
                     end
                  end
                  count <= count + 1'b1;
                  // With BANKS=1 the compare is against 0, so every word wraps.
                  if (bank_sel == SELW'(BANKS - 1)) begin
                     bank_sel <= '0;
                     addr     <= addr + 1'b1;
                  end else begin
                     bank_sel <= bank_sel + 1'b1;
                  end
                  if (final_word) begin
                     if (!s_axis_tlast) error <= 1'b1;
                     state <= FIN;
                  end else if (s_axis_tlast) begin
                     // Early tlast: keep the word, flag it, stop accepting.
                     error <= 1'b1;
                     state <= FIN;
                  end
               end
            end
            FIN:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bram_stream_loader.sv
`timescale 1ns / 1ps
// Self-checking bench for bram_stream_loader (BANKS=4, WIDTH=16, DEPTH=256).
module tb_bram_stream_loader;

   localparam int BANKS = 4;
   localparam int WIDTH = 16;
   localparam int DEPTH = 256;
   localparam int ADDR  = 8;
   localparam int WE    = 2;
   localparam int LEN_W = 11;

   logic                   clk = 1'b0;
   logic                   rstn = 1'b0;
   logic                   start = 1'b0;
   logic [LEN_W-1:0]       length = '0;
   logic                   busy, done, error;
   logic [WIDTH-1:0]       s_axis_tdata = '0;
   logic                   s_axis_tvalid = 1'b0;
   logic                   s_axis_tready;
   logic                   s_axis_tlast = 1'b0;
   logic [BANKS-1:0]       ena;
   logic [BANKS*WE-1:0]    wea;
   logic [BANKS*ADDR-1:0]  addra;
   logic [BANKS*WIDTH-1:0] dina;

   bram_stream_loader #(
      .BANKS(BANKS), .WIDTH(WIDTH), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rstn(rstn), .start(start), .length(length),
      .busy(busy), .done(done), .error(error),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
      .ena(ena), .wea(wea), .addra(addra), .dina(dina)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Stimulus words and the index carrying tlast (-1 = never)
   logic [WIDTH-1:0] words [1024];
   int               last_at;

   // Observed A-port activity, sampled on the falling edge
   int               wb[$];
   int               wa[$];
   logic [WIDTH-1:0] wd[$];
   logic [WIDTH-1:0] cap_mem [BANKS][DEPTH];
   int               n_done, n_busy, n_wcyc, n_bad, hot;

   always @(negedge clk) begin
      if (rstn) begin
         hot = 0;
         for (int b = 0; b < BANKS; b++) begin
            if (wea[b*WE +: WE] !== {WE{ena[b]}}) n_bad++;
            if (ena[b] === 1'b1) begin
               hot++;
               wb.push_back(b);
               wa.push_back(int'(addra[b*ADDR +: ADDR]));
               wd.push_back(dina[b*WIDTH +: WIDTH]);
               cap_mem[b][addra[b*ADDR +: ADDR]] = dina[b*WIDTH +: WIDTH];
            end
         end
         if (hot > 1) n_bad++;
         if (hot > 0) n_wcyc++;
         if (done === 1'b1) n_done++;
         if (busy === 1'b1) n_busy++;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_mon();
      wb.delete(); wa.delete(); wd.delete();
      n_done = 0; n_busy = 0; n_wcyc = 0; n_bad = 0;
   endtask

   task automatic fill_words(input int n, input bit rnd);
      for (int i = 0; i < n; i++) words[i] = rnd ? WIDTH'($urandom) : WIDTH'(i + 1);
   endtask

   // Returns at the falling edge right after the start pulse was accepted.
   task automatic do_start(input int len);
      @(negedge clk);
      clear_mon();
      start  = 1'b1;
      length = LEN_W'(len);
      @(negedge clk);
      start  = 1'b0;
   endtask

   // Offers words while tready is high. Returns at a falling edge.
   task automatic feed(input int n, input int stall_pct, input bit use_pat,
                       input logic [7:0] pat, output int taken);
      bit v;
      int cyc;
      taken = 0;
      cyc   = 0;
      while (taken < n && s_axis_tready === 1'b1 && cyc < 5000) begin
         v = use_pat ? pat[cyc % 8] : ($urandom_range(99) >= stall_pct);
         s_axis_tvalid = v;
         s_axis_tdata  = words[taken];
         s_axis_tlast  = (taken == last_at);
         @(negedge clk);
         if (v) taken++;
         cyc++;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({busy, done, error, s_axis_tready, ena, wea, addra, dina} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got busy=%b done=%b error=%b tready=%b ena=%b wea=%b",
                  busy, done, error, s_axis_tready, ena, wea);
      end
      rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int taken;
      fill_words(8, 1'b0);
      last_at = 7;
      do_start(8);
      feed(8, 0, 1'b0, 8'h00, taken);
      repeat (3) @(negedge clk);
      n_checks++;
      if (taken != 8 || wb.size() != 8) begin
         n_fail++;
         $display("FAIL basic_count got taken=%0d writes=%0d, want 8 and 8", taken, wb.size());
      end
      for (int k = 0; k < wb.size() && k < 8; k++) begin
         n_checks++;
         if (wb[k] !== k % BANKS || wa[k] !== k / BANKS || wd[k] !== words[k]) begin
            n_fail++;
            $display("FAIL basic_write[%0d] got bank %0d addr %0d data %h, want %0d %0d %h",
                     k, wb[k], wa[k], wd[k], k % BANKS, k / BANKS, words[k]);
         end
      end
      n_checks++;
      if (cap_mem[0][0] !== 16'h0001 || cap_mem[0][1] !== 16'h0005 ||
          cap_mem[3][0] !== 16'h0004 || cap_mem[3][1] !== 16'h0008) begin
         n_fail++;
         $display("FAIL basic_readback got b0=%h,%h b3=%h,%h, want 0001,0005 0004,0008",
                  cap_mem[0][0], cap_mem[0][1], cap_mem[3][0], cap_mem[3][1]);
      end
      n_checks++;
      if (n_busy != 8 || n_done != 1 || error !== 1'b0 || n_bad != 0) begin
         n_fail++;
         $display("FAIL basic_status got busy_cycles=%0d done=%0d error=%b bad=%0d, want 8 1 0 0",
                  n_busy, n_done, error, n_bad);
      end
   endtask

   task automatic test_stalls();
      int taken;
      fill_words(5, 1'b1);
      last_at = 4;
      do_start(5);
      // A start pulse during the load must be ignored.
      start  = 1'b1;
      length = LEN_W'(3);
      feed(5, 0, 1'b1, 8'b1101_1001, taken);
      start  = 1'b0;
      repeat (4) @(negedge clk);
      n_checks++;
      if (taken != 5 || n_wcyc != 5 || n_busy != 8) begin
         n_fail++;
         $display("FAIL stall_counts got taken=%0d write_cycles=%0d busy=%0d, want 5 5 8",
                  taken, n_wcyc, n_busy);
      end
      for (int k = 0; k < wb.size() && k < 5; k++) begin
         n_checks++;
         if (wb[k] !== k % BANKS || wa[k] !== k / BANKS || wd[k] !== words[k]) begin
            n_fail++;
            $display("FAIL stall_write[%0d] got bank %0d addr %0d data %h, want %0d %0d %h",
                     k, wb[k], wa[k], wd[k], k % BANKS, k / BANKS, words[k]);
         end
      end
      n_checks++;
      if (n_done != 1 || error !== 1'b0 || n_bad != 0 || wb.size() != 5) begin
         n_fail++;
         $display("FAIL stall_status got done=%0d error=%b bad=%0d writes=%0d, want 1 0 0 5",
                  n_done, error, n_bad, wb.size());
      end
   endtask

   task automatic test_early_tlast();
      int taken;
      bit rdy_seen;
      fill_words(6, 1'b1);
      last_at = 2;
      do_start(6);
      feed(6, 20, 1'b0, 8'h00, taken);
      rdy_seen = 1'b0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = words[3];
      repeat (4) begin
         @(negedge clk);
         if (s_axis_tready === 1'b1) rdy_seen = 1'b1;
      end
      s_axis_tvalid = 1'b0;
      n_checks++;
      if (taken != 3 || wb.size() != 3 || rdy_seen) begin
         n_fail++;
         $display("FAIL early_tlast_count got taken=%0d writes=%0d ready_after=%b, want 3 3 0",
                  taken, wb.size(), rdy_seen);
      end
      for (int k = 0; k < wb.size() && k < 3; k++) begin
         n_checks++;
         if (wb[k] !== k % BANKS || wa[k] !== k / BANKS || wd[k] !== words[k]) begin
            n_fail++;
            $display("FAIL early_write[%0d] got bank %0d addr %0d data %h, want %0d %0d %h",
                     k, wb[k], wa[k], wd[k], k % BANKS, k / BANKS, words[k]);
         end
      end
      n_checks++;
      if (error !== 1'b1 || n_done != 1) begin
         n_fail++;
         $display("FAIL early_tlast_status got error=%b done=%0d, want 1 1", error, n_done);
      end
   endtask

   task automatic test_missing_tlast();
      int taken;
      fill_words(4, 1'b1);
      last_at = -1;
      do_start(4);
      feed(4, 30, 1'b0, 8'h00, taken);
      repeat (3) @(negedge clk);
      n_checks++;
      if (taken != 4 || wb.size() != 4 || error !== 1'b1 || n_done != 1) begin
         n_fail++;
         $display("FAIL missing_tlast got taken=%0d writes=%0d error=%b done=%0d, want 4 4 1 1",
                  taken, wb.size(), error, n_done);
      end
      fill_words(2, 1'b1);
      last_at = 1;
      do_start(2);
      feed(2, 0, 1'b0, 8'h00, taken);
      repeat (3) @(negedge clk);
      n_checks++;
      if (taken != 2 || wb.size() != 2 || error !== 1'b0 || n_done != 1) begin
         n_fail++;
         $display("FAIL error_clear got taken=%0d writes=%0d error=%b done=%0d, want 2 2 0 1",
                  taken, wb.size(), error, n_done);
      end
   endtask

   task automatic test_bounds();
      int taken;
      int mism;
      do_start(1025);
      repeat (3) @(negedge clk);
      n_checks++;
      if (n_done != 1 || wb.size() != 0 || error !== 1'b1 || n_busy != 0) begin
         n_fail++;
         $display("FAIL len_over got done=%0d writes=%0d error=%b busy=%0d, want 1 0 1 0",
                  n_done, wb.size(), error, n_busy);
      end
      do_start(0);
      repeat (3) @(negedge clk);
      n_checks++;
      if (n_done != 1 || wb.size() != 0 || error !== 1'b0 || n_busy != 0) begin
         n_fail++;
         $display("FAIL len_zero got done=%0d writes=%0d error=%b busy=%0d, want 1 0 0 0",
                  n_done, wb.size(), error, n_busy);
      end
      fill_words(1024, 1'b1);
      last_at = 1023;
      do_start(1024);
      feed(1024, 0, 1'b0, 8'h00, taken);
      repeat (3) @(negedge clk);
      mism = 0;
      for (int b = 0; b < BANKS; b++)
         for (int a = 0; a < DEPTH; a++)
            if (cap_mem[b][a] !== words[a * BANKS + b]) mism++;
      n_checks++;
      if (taken != 1024 || wb.size() != 1024 || mism != 0) begin
         n_fail++;
         $display("FAIL full_fill got taken=%0d writes=%0d readback_mismatches=%0d, want 1024 1024 0",
                  taken, wb.size(), mism);
      end
      n_checks++;
      if (wb.size() != 1024 || wb[1023] != 3 || wa[1023] != 255 || wd[1023] !== words[1023]) begin
         n_fail++;
         $display("FAIL full_fill_last got writes=%0d, want last word in bank 3 addr 255 data %h",
                  wb.size(), words[1023]);
      end
      n_checks++;
      if (error !== 1'b0 || n_done != 1 || n_busy != 1024 || n_bad != 0) begin
         n_fail++;
         $display("FAIL full_fill_status got error=%b done=%0d busy=%0d bad=%0d, want 0 1 1024 0",
                  error, n_done, n_busy, n_bad);
      end
   endtask

   task automatic test_random();
      int taken, len, mode, exp_n, mism;
      bit exp_err;
      for (int it = 0; it < 12; it++) begin
         len  = $urandom_range(40, 1);
         mode = $urandom_range(2, 0);
         if (mode == 0 || (mode == 1 && len == 1)) last_at = len - 1;
         else if (mode == 1) last_at = $urandom_range(len - 2, 0);
         else last_at = -1;
         // The transfer stops at tlast or at length, whichever comes first.
         exp_n   = (last_at >= 0) ? last_at + 1 : len;
         exp_err = (last_at != len - 1);
         fill_words(len, 1'b1);
         do_start(len);
         feed(len, $urandom_range(60, 0), 1'b0, 8'h00, taken);
         repeat (2) @(negedge clk);
         mism = 0;
         for (int k = 0; k < wb.size() && k < exp_n; k++)
            if (wb[k] !== k % BANKS || wa[k] !== k / BANKS || wd[k] !== words[k]) mism++;
         n_checks++;
         if (taken != exp_n || wb.size() != exp_n || mism != 0 || n_bad != 0) begin
            n_fail++;
            $display("FAIL rand[%0d] len=%0d last=%0d got taken=%0d writes=%0d mism=%0d bad=%0d, want %0d",
                     it, len, last_at, taken, wb.size(), mism, n_bad, exp_n);
         end
         n_checks++;
         if (error !== exp_err || n_done != 1) begin
            n_fail++;
            $display("FAIL rand_status[%0d] got error=%b done=%0d, want %b 1",
                     it, error, n_done, exp_err);
         end
      end
   endtask

   task automatic test_async_reset();
      int taken;
      fill_words(8, 1'b1);
      last_at = 7;
      do_start(8);
      s_axis_tvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         s_axis_tdata = words[i];
         @(negedge clk);
      end
      s_axis_tvalid = 1'b0;
      #2;
      rstn = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, error, s_axis_tready, ena, wea, addra, dina} !== '0) begin
         n_fail++;
         $display("FAIL async_reset got busy=%b done=%b error=%b tready=%b ena=%b wea=%b",
                  busy, done, error, s_axis_tready, ena, wea);
      end
      @(negedge clk);
      rstn = 1'b1;
      fill_words(2, 1'b1);
      last_at = 1;
      do_start(2);
      feed(2, 0, 1'b0, 8'h00, taken);
      repeat (2) @(negedge clk);
      n_checks++;
      if (taken != 2 || wb.size() != 2 || n_done != 1 || error !== 1'b0) begin
         n_fail++;
         $display("FAIL after_reset got taken=%0d writes=%0d done=%0d error=%b, want 2 2 1 0",
                  taken, wb.size(), n_done, error);
      end
      for (int k = 0; k < wb.size() && k < 2; k++) begin
         n_checks++;
         if (wb[k] !== k || wa[k] !== 0 || wd[k] !== words[k]) begin
            n_fail++;
            $display("FAIL after_reset_write[%0d] got bank %0d addr %0d data %h, want %0d 0 %h",
                     k, wb[k], wa[k], wd[k], k, words[k]);
         end
      end
   endtask

   initial begin
      clear_mon();
      test_reset();
      test_basic();
      test_stalls();
      test_early_tlast();
      test_missing_tlast();
      test_bounds();
      test_random();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
